// File: rtl/fuzz_crash_logger_pkg.sv
// Shared constants, header layout and sizing helper for the fuzz crash logger.
package fuzz_log_pkg;

    localparam int         LOG_WORD_W    = 32;
    localparam logic [7:0] LOG_MAGIC     = 8'hA5;

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_HANG_BIT  = 23;
    localparam int HDR_COLL_BIT  = 22;
    localparam int HDR_COV_LSB   = 8;
    localparam int HDR_SEQ_LSB   = 0;

    typedef struct packed {
        logic [7:0] magic;
        logic       hang;
        logic       collision;
        logic [5:0] rsvd;
        logic [7:0] coverage;
        logic [7:0] seq;
    } log_header_t;

    function automatic int words_per_record(int in_w, int out_w);
        return 2 + in_w / LOG_WORD_W + out_w / LOG_WORD_W;
    endfunction

endpackage

// File: rtl/fuzz_crash_logger_if.sv
// Word-wide valid/ready readout stream from the crash logger to the host.
interface fuzz_log_if;
    import fuzz_log_pkg::*;

    logic [LOG_WORD_W-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/fuzz_crash_logger_fifo.sv
// Generic synchronous FIFO; a pop frees the slot for a same-cycle push when full.
module fuzz_log_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fuzz_crash_logger.sv
// Captures timestamped crash records on fuzzer alarm edges and streams them out word by word.
//   state   | meaning
//   IDLE    | no stored record, m_valid low
//   SEND    | presenting word idx of the head record
module fuzz_crash_logger
    import fuzz_log_pkg::*;
#(
    parameter int INPUT_WIDTH  = 256,
    parameter int OUTPUT_WIDTH = 128,
    parameter int LOG_DEPTH    = 8,
    parameter int DEDUP_EN     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           log_en,
    input  logic                           clear,
    input  logic                           alarm_hang,
    input  logic                           alarm_collision,
    input  logic [7:0]                     coverage_score,
    input  logic [INPUT_WIDTH-1:0]         error_input,
    input  logic [OUTPUT_WIDTH-1:0]        error_output,
    fuzz_log_if.master                     log_bus,
    output logic [$clog2(LOG_DEPTH):0]     log_count,
    output logic [15:0]                    drop_count,
    output logic [15:0]                    dup_count
);
    localparam int WPR   = words_per_record(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int IDX_W = $clog2(WPR);
    localparam int CW    = $clog2(LOG_DEPTH) + 1;
    localparam int REC_W = 50 + INPUT_WIDTH + OUTPUT_WIDTH;
    localparam int TS_LSB = OUTPUT_WIDTH + INPUT_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [31:0]            ts;
    logic                   hang_q;
    logic                   coll_q;
    logic [7:0]             seq;
    logic [INPUT_WIDTH-1:0] last_in;
    logic                   last_valid;

    logic                   rise, is_dup, want, accept, drop, dup_hit;
    logic                   hs, last_word, pop;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [REC_W-1:0]       rec_in, head;
    log_header_t            hdr;
    logic [WPR*LOG_WORD_W-1:0] words;

    assign rise      = log_en & ((alarm_hang & ~hang_q) | (alarm_collision & ~coll_q));
    assign is_dup    = (DEDUP_EN != 0) && last_valid && (error_input == last_in);
    assign want      = rise & ~clear & ~is_dup;
    assign dup_hit   = rise & ~clear & is_dup;
    assign hs        = log_bus.m_valid & log_bus.m_ready;
    assign last_word = (state == ST_SEND) && !fifo_empty && (idx == IDX_W'(WPR - 1));
    assign pop       = hs & last_word;
    // The head's last-word handshake frees a slot in the same cycle a full FIFO would refuse.
    assign accept    = want & (~fifo_full | pop);
    assign drop      = want & fifo_full & ~pop;

    assign rec_in = {alarm_hang, alarm_collision, coverage_score, seq, ts, error_input, error_output};

    fuzz_log_fifo #(.DATA_W(REC_W), .DEPTH(LOG_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (accept),
        .din   (rec_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        hdr           = '0;
        hdr.magic     = LOG_MAGIC;
        hdr.hang      = head[TS_LSB + 49];
        hdr.collision = head[TS_LSB + 48];
        hdr.coverage  = head[TS_LSB + 40 +: 8];
        hdr.seq       = head[TS_LSB + 32 +: 8];
    end

    assign words = {head[OUTPUT_WIDTH-1:0], head[OUTPUT_WIDTH +: INPUT_WIDTH], head[TS_LSB +: 32], hdr};

    assign log_bus.m_valid = (state == ST_SEND);
    assign log_bus.m_last  = last_word;
    assign log_bus.m_data  = (state == ST_SEND) ? words[int'(idx) * LOG_WORD_W +: LOG_WORD_W] : '0;
    assign log_count       = fifo_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            ts         <= '0;
            hang_q     <= 1'b0;
            coll_q     <= 1'b0;
            seq        <= '0;
            last_in    <= '0;
            last_valid <= 1'b0;
            drop_count <= '0;
            dup_count  <= '0;
        end else begin
            ts     <= ts + 32'd1;
            hang_q <= alarm_hang;
            coll_q <= alarm_collision;
            if (clear) begin
                state      <= ST_IDLE;
                idx        <= '0;
                seq        <= '0;
                last_valid <= 1'b0;
                drop_count <= '0;
                dup_count  <= '0;
            end else begin
                if (accept) begin
                    seq        <= seq + 8'd1;
                    last_in    <= error_input;
                    last_valid <= 1'b1;
                end
                if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                if (dup_hit && dup_count != 16'hFFFF) dup_count <= dup_count + 16'd1;
                case (state)
                    ST_IDLE: begin
                        idx <= '0;
                        if (accept) state <= ST_SEND;
                    end
                    default: begin
                        if (hs) begin
                            if (last_word) begin
                                idx <= '0;
                                if (fifo_count == CW'(1) && !accept) state <= ST_IDLE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
